// File: rtl/dynamixel_status_receiver_if.sv
// Bus-side signals of the Dynamixel 2.0 status receiver.
// Output handshake: packet_valid, packet_crc_error and framing_error are
// single-cycle pulses with no ready/back-pressure; packet_id, packet_error,
// param_count and value are stable registers that change only in the cycle
// packet_valid is high, so a consumer may sample them on that pulse or later.
interface dynamixel_status_receiver_if;
  logic        pin;
  logic        enable;
  logic        packet_valid;
  logic        packet_crc_error;
  logic        framing_error;
  logic [7:0]  packet_id;
  logic [7:0]  packet_error;
  logic [15:0] param_count;
  logic [31:0] value;
  logic [1:0]  dbg_uart_state;
  logic [3:0]  dbg_parser_state;

  modport master (
    output pin, enable,
    input  packet_valid, packet_crc_error, framing_error,
    input  packet_id, packet_error, param_count, value,
    input  dbg_uart_state, dbg_parser_state
  );

  modport slave (
    input  pin, enable,
    output packet_valid, packet_crc_error, framing_error,
    output packet_id, packet_error, param_count, value,
    output dbg_uart_state, dbg_parser_state
  );
endinterface

// File: rtl/dynamixel_status_receiver.sv
// Dynamixel Protocol 2.0 status packet receiver: 8N1 UART sampler followed by
// a byte-level packet parser with de-stuffing and CRC-16 (poly 0x8005) check.
module dynamixel_status_receiver #(
  parameter int clocks_per_bit = 3
) (
  input logic                         clock,
  input logic                         reset,
  dynamixel_status_receiver_if.slave  bus
);

  localparam int CW   = $clog2(clocks_per_bit);
  localparam int HALF = clocks_per_bit / 2;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic [3:0] {
    P_H1, P_H2, P_H3, P_RSV, P_ID, P_LEN_L, P_LEN_H,
    P_INST, P_ERR, P_PARAM, P_CRC_L, P_CRC_H
  } parser_state_t;

  // One CRC-16 byte step, MSB first, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    end
    return c;
  endfunction

  logic [1:0]    r_sync;
  logic          r_rx_prev;
  uart_state_t   r_ustate;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_byte_stb;
  logic          r_framing_error;

  parser_state_t r_pstate;
  logic [15:0]   r_crc;
  logic [15:0]   r_len;
  logic [7:0]    r_len_l;
  logic [7:0]    r_crc_l;
  logic [23:0]   r_hist;
  logic [7:0]    r_id_stage;
  logic [7:0]    r_err_stage;
  logic [15:0]   r_cnt_stage;
  logic [31:0]   r_val_stage;
  logic          r_packet_valid;
  logic          r_packet_crc_error;
  logic [7:0]    r_packet_id;
  logic [7:0]    r_packet_error;
  logic [15:0]   r_param_count;
  logic [31:0]   r_value;

  logic          w_rx;
  logic [15:0]   w_crc_next;
  logic [15:0]   w_crc_from0;
  logic [15:0]   w_crc_ffff;
  logic          w_stuffed;

  assign w_rx        = r_sync[1];
  assign w_crc_next  = crc16_byte(r_crc, r_byte);
  assign w_crc_from0 = crc16_byte(16'h0000, r_byte);
  assign w_crc_ffff  = crc16_byte(crc16_byte(16'h0000, 8'hFF), 8'hFF);
  // An FD right after a raw FF FF FD is a stuffing byte.
  assign w_stuffed   = (r_hist == 24'hFFFFFD) && (r_byte == 8'hFD);

  // Two-flop synchronizer plus previous sample for falling-edge detection; idle-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], bus.pin};
      r_rx_prev <= w_rx;
    end
  end

  // UART 8N1 receiver: start validation at half bit, then one sample per bit period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ustate        <= U_IDLE;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_shift         <= '0;
      r_byte          <= '0;
      r_byte_stb      <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_byte_stb      <= 1'b0;
      r_framing_error <= 1'b0;
      if (!bus.enable) begin
        r_ustate <= U_IDLE;
      end else begin
        case (r_ustate)
          U_IDLE: begin
            if (r_rx_prev && !w_rx) begin
              r_ustate <= U_START;
              r_cnt    <= '0;
            end
          end
          U_START: begin
            if (r_cnt == CW'(HALF - 1)) begin
              r_cnt <= '0;
              r_idx <= '0;
              r_ustate <= w_rx ? U_IDLE : U_DATA;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          U_DATA: begin
            if (r_cnt == CW'(clocks_per_bit - 1)) begin
              r_cnt   <= '0;
              r_shift <= {w_rx, r_shift[7:1]};
              if (r_idx == 3'd7) r_ustate <= U_STOP;
              else               r_idx    <= r_idx + 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          U_STOP: begin
            if (r_cnt == CW'(clocks_per_bit - 1)) begin
              r_cnt    <= '0;
              r_ustate <= U_IDLE;
              if (w_rx) begin
                r_byte     <= r_shift;
                r_byte_stb <= 1'b1;
              end else begin
                r_framing_error <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_ustate <= U_IDLE;
        endcase
      end
    end
  end

  // Packet parser: header match, length tracking, de-stuffing, CRC and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pstate           <= P_H1;
      r_crc              <= '0;
      r_len              <= '0;
      r_len_l            <= '0;
      r_crc_l            <= '0;
      r_hist             <= '0;
      r_id_stage         <= '0;
      r_err_stage        <= '0;
      r_cnt_stage        <= '0;
      r_val_stage        <= '0;
      r_packet_valid     <= 1'b0;
      r_packet_crc_error <= 1'b0;
      r_packet_id        <= '0;
      r_packet_error     <= '0;
      r_param_count      <= '0;
      r_value            <= '0;
    end else begin
      r_packet_valid     <= 1'b0;
      r_packet_crc_error <= 1'b0;
      if (!bus.enable || r_framing_error) begin
        r_pstate <= P_H1;
      end else if (r_byte_stb) begin
        r_hist <= {r_hist[15:0], r_byte};
        case (r_pstate)
          P_H1: begin
            if (r_byte == 8'hFF) begin
              r_crc    <= w_crc_from0;
              r_pstate <= P_H2;
            end
          end
          P_H2: begin
            r_crc    <= w_crc_next;
            r_pstate <= (r_byte == 8'hFF) ? P_H3 : P_H1;
          end
          P_H3: begin
            if (r_byte == 8'hFD) begin
              r_crc    <= w_crc_next;
              r_pstate <= P_RSV;
            end else if (r_byte == 8'hFF) begin
              r_crc    <= w_crc_ffff;
            end else begin
              r_pstate <= P_H1;
            end
          end
          P_RSV: begin
            r_crc    <= w_crc_next;
            r_pstate <= (r_byte == 8'h00) ? P_ID : P_H1;
          end
          P_ID: begin
            r_crc      <= w_crc_next;
            r_id_stage <= r_byte;
            r_pstate   <= P_LEN_L;
          end
          P_LEN_L: begin
            r_crc    <= w_crc_next;
            r_len_l  <= r_byte;
            r_pstate <= P_LEN_H;
          end
          P_LEN_H: begin
            r_crc <= w_crc_next;
            if ({r_byte, r_len_l} < 16'd4) begin
              r_pstate <= P_H1;
            end else begin
              r_len    <= {r_byte, r_len_l} - 16'd4;
              r_pstate <= P_INST;
            end
          end
          P_INST: begin
            r_crc    <= w_crc_next;
            r_pstate <= (r_byte == 8'h55) ? P_ERR : P_H1;
          end
          P_ERR: begin
            r_crc       <= w_crc_next;
            r_err_stage <= r_byte;
            r_cnt_stage <= '0;
            r_val_stage <= '0;
            r_pstate    <= (r_len == 16'd0) ? P_CRC_L : P_PARAM;
          end
          P_PARAM: begin
            r_crc <= w_crc_next;
            r_len <= r_len - 16'd1;
            if (!w_stuffed) begin
              if (r_cnt_stage < 16'd4) r_val_stage[{r_cnt_stage[1:0], 3'b000} +: 8] <= r_byte;
              r_cnt_stage <= r_cnt_stage + 16'd1;
            end
            if (r_len == 16'd1) r_pstate <= P_CRC_L;
          end
          P_CRC_L: begin
            r_crc_l  <= r_byte;
            r_pstate <= P_CRC_H;
          end
          P_CRC_H: begin
            r_pstate <= P_H1;
            if ({r_byte, r_crc_l} == r_crc) begin
              r_packet_valid <= 1'b1;
              r_packet_id    <= r_id_stage;
              r_packet_error <= r_err_stage;
              r_param_count  <= r_cnt_stage;
              r_value        <= r_val_stage;
            end else begin
              r_packet_crc_error <= 1'b1;
            end
          end
          default: r_pstate <= P_H1;
        endcase
      end
    end
  end

  assign bus.packet_valid     = r_packet_valid;
  assign bus.packet_crc_error = r_packet_crc_error;
  assign bus.framing_error    = r_framing_error;
  assign bus.packet_id        = r_packet_id;
  assign bus.packet_error     = r_packet_error;
  assign bus.param_count      = r_param_count;
  assign bus.value            = r_value;
  assign bus.dbg_uart_state   = r_ustate;
  assign bus.dbg_parser_state = r_pstate;

endmodule

// File: tb/tb_dynamixel_status_receiver.sv
// Testbench for dynamixel_status_receiver: serial driver, packet-level
// reference model, event scoreboard and final report.
module tb_dynamixel_status_receiver;

  localparam int CPB = 3;
  localparam int W   = 67;  // {kind[2:0], id, err, count, value}

  typedef logic [7:0] bq_t[$];

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dynamixel_status_receiver_if bus();

  dynamixel_status_receiver #(.clocks_per_bit(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [7:0]  m_id, m_err;
  logic [15:0] m_cnt;
  logic [31:0] m_val;

  function automatic logic [W-1:0] pack(input logic [2:0] k, input logic [7:0] id, input logic [7:0] err,
                                        input logic [15:0] cnt, input logic [31:0] v);
    return {k, id, err, cnt, v};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bitwise CRC-16 (poly 0x8005, MSB first) over the first n bytes.
  function automatic logic [15:0] crc_ref(input bq_t q, input int n);
    logic [15:0] c;
    logic fb;
    c = 16'h0000;
    for (int i = 0; i < n; i++) begin
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ q[i][j];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  // Build a status packet from raw (already stuffed) parameter bytes.
  function automatic bq_t build(input logic [7:0] id, input logic [7:0] err, input bq_t params, input logic bad_crc);
    bq_t q;
    logic [15:0] len, c;
    len = 16'(params.size() + 4);
    q = '{8'hFF, 8'hFF, 8'hFD, 8'h00, id, len[7:0], len[15:8], 8'h55, err};
    foreach (params[i]) q.push_back(params[i]);
    c = crc_ref(q, q.size());
    if (bad_crc) c = c ^ 16'h0100;
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    return q;
  endfunction

  // Decode one complete packet from its raw bytes.
  task automatic model(input bq_t q, output logic ok, output logic [7:0] id, output logic [7:0] err,
                       output logic [15:0] cnt, output logic [31:0] val);
    int np, k;
    logic [15:0] rx;
    np  = int'({q[6], q[5]}) - 4;
    id  = q[4];
    err = q[8];
    val = '0;
    k   = 0;
    for (int i = 9; i < 9 + np; i++) begin
      if (!(q[i] == 8'hFD && q[i-1] == 8'hFD && q[i-2] == 8'hFF && q[i-3] == 8'hFF)) begin
        if (k < 4) val[8*k +: 8] = q[i];
        k++;
      end
    end
    cnt = 16'(k);
    rx  = {q[10+np], q[9+np]};
    ok  = (rx == crc_ref(q, 9 + np));
  endtask

  task automatic expect_pkt(input bq_t q);
    logic ok;
    logic [7:0] id, err;
    logic [15:0] cnt;
    logic [31:0] val;
    model(q, ok, id, err, cnt, val);
    if (ok) begin
      m_id = id; m_err = err; m_cnt = cnt; m_val = val;
      exp_q.push_back(pack(3'b100, id, err, cnt, val));
    end else begin
      exp_q.push_back(pack(3'b010, m_id, m_err, m_cnt, m_val));
    end
  endtask

  task automatic expect_const(input logic [7:0] id, input logic [7:0] err, input logic [15:0] cnt, input logic [31:0] val);
    m_id = id; m_err = err; m_cnt = cnt; m_val = val;
    exp_q.push_back(pack(3'b100, id, err, cnt, val));
  endtask

  // ---------------- driver ----------------
  task automatic drive_bit(input logic b);
    bus.pin = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_pkt(input bq_t q, input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(q[i]);
  endtask

  task automatic check_outputs(input string name);
    check(name, pack({bus.packet_valid, bus.packet_crc_error, bus.framing_error},
                     bus.packet_id, bus.packet_error, bus.param_count, bus.value),
          pack(3'b000, m_id, m_err, m_cnt, m_val));
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] act;
    forever begin
      @(negedge clock);
      if (!reset && (bus.packet_valid || bus.packet_crc_error || bus.framing_error)) begin
        act = pack({bus.packet_valid, bus.packet_crc_error, bus.framing_error},
                   bus.packet_id, bus.packet_error, bus.param_count, bus.value);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event actual=%h required=none", act);
        end else begin
          check("event", act, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bq_t ping, rd, ping_bad, q, params;
    int np, r;
    reset = 1'b1;
    bus.pin = 1'b1;
    bus.enable = 1'b1;
    m_id = '0; m_err = '0; m_cnt = '0; m_val = '0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_outputs("reset_state");

    // Reference status packets
    ping     = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55, 8'h00, 8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
    rd       = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h08, 8'h00, 8'h55, 8'h00, 8'hA6, 8'h00, 8'h00, 8'h00, 8'h8C, 8'hC0};
    ping_bad = ping;
    ping_bad[13] = 8'h5C;
    expect_const(8'h01, 8'h00, 16'd3, 32'h00260406);
    send_pkt(ping, ping.size());
    expect_const(8'h01, 8'h00, 16'd4, 32'h000000A6);
    send_pkt(rd, rd.size());
    exp_q.push_back(pack(3'b010, m_id, m_err, m_cnt, m_val));
    send_pkt(ping_bad, ping_bad.size());
    idle_bits(2);
    check_outputs("hold_after_crc_error");

    // Glitch on idle line, noise byte, then stuffed parameters
    bus.pin = 1'b0;
    @(negedge clock);
    idle_bits(2);
    send_byte(8'h33);
    idle_bits(1);
    q = build(8'h01, 8'h00, '{8'hFF, 8'hFF, 8'hFD, 8'hFD}, 1'b0);
    expect_const(8'h01, 8'h00, 16'd3, 32'h00FDFFFF);
    send_pkt(q, q.size());

    // Repeated FF in the header and a zero-parameter packet
    send_byte(8'hFF);
    q = build(8'h2A, 8'h80, '{}, 1'b0);
    expect_pkt(q);
    send_pkt(q, q.size());

    // LEN below 4 is dropped silently
    q = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h05, 8'h03, 8'h00};
    send_pkt(q, q.size());
    idle_bits(2);

    // Framing error mid-packet, then a good packet
    q = build(8'h07, 8'h01, '{8'h11, 8'h22}, 1'b0);
    send_pkt(q, 7);
    exp_q.push_back(pack(3'b001, m_id, m_err, m_cnt, m_val));
    send_byte(q[7], 1'b0);
    idle_bits(2);
    q = build(8'h08, 8'h02, '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77}, 1'b0);
    expect_pkt(q);
    send_pkt(q, q.size());

    // Reset asserted mid-PARAM
    q = build(8'h09, 8'h00, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1'b0);
    send_pkt(q, 11);
    bus.pin = 1'b0;
    repeat (CPB + 1) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    bus.pin = 1'b1;
    reset = 1'b0;
    m_id = '0; m_err = '0; m_cnt = '0; m_val = '0;
    repeat (2) @(negedge clock);
    check_outputs("reset_mid_param");
    q = build(8'h0A, 8'h00, '{8'hAB}, 1'b0);
    expect_pkt(q);
    send_pkt(q, q.size());

    // enable dropped during a packet
    q = build(8'h0B, 8'h04, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0);
    send_pkt(q, 6);
    bus.enable = 1'b0;
    for (int i = 6; i < q.size(); i++) send_byte(q[i]);
    idle_bits(2);
    bus.enable = 1'b1;
    idle_bits(1);
    check_outputs("hold_while_disabled");
    q = build(8'h0C, 8'h00, '{8'h10, 8'h20, 8'h30}, 1'b0);
    expect_pkt(q);
    send_pkt(q, q.size());

    // Randomized packets, mostly back to back
    for (int n = 0; n < 30; n++) begin
      params = {};
      np = $urandom_range(0, 7);
      for (int i = 0; i < np; i++) begin
        r = $urandom_range(0, 3);
        params.push_back(r == 0 ? 8'hFF : (r == 1 ? 8'hFD : 8'($urandom_range(0, 255))));
      end
      q = build(8'($urandom_range(0, 255)), 8'($urandom_range(0, 254)), params, $urandom_range(0, 3) == 0);
      expect_pkt(q);
      send_pkt(q, q.size());
      idle_bits($urandom_range(0, 2));
    end

    // Drain
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
    idle_bits(4);
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dynamixel_status_receiver.md
Name: dynamixel_status_receiver

Overview:
- Receives Dynamixel Protocol 2.0 status packets on the half-duplex bus while the sync-write transmitter is idle.
- Samples the raw line (8N1 UART) and parses the packet. It removes byte stuffing, checks the CRC, and presents the ID, error byte and up to 4 parameter bytes.
- Sits beside dynamixel_sync_write in the top level. Its input is the tristated bus line; its enable comes from the inverted transmitter sending flag.

Parameters:
- clocks_per_bit, 3, clock cycles per UART bit (clock_frequency / dynamixel_baudrate); must be >= 2.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pin  input  1  raw bus line, idle high, asynchronous to clock
- enable  input  1  1 = listen; 0 = transmitter owns the bus
- packet_valid  output  1  one-cycle pulse: good packet received, output fields updated
- packet_crc_error  output  1  one-cycle pulse: complete packet with CRC mismatch
- framing_error  output  1  one-cycle pulse: stop bit sampled low
- packet_id  output  8  ID of last good packet
- packet_error  output  8  error byte of last good packet
- param_count  output  16  number of de-stuffed parameter bytes in last good packet
- value  output  32  first 4 parameter bytes, little-endian (byte0 = value[7:0]); missing bytes = 0

Behaviour:
- Reset: all outputs 0; UART receiver idle; parser in H1; CRC = 0. Reset mid-packet aborts the packet silently.
- pin passes through a 2-flop synchronizer before any use.
- UART start bit:
  - A falling edge of the synchronized line while idle starts a bit timer.
  - At clocks_per_bit/2 (integer division) the line is re-sampled. If it is high, this is a glitch: return to idle.
- UART data and stop:
  - 8 data bits, LSB first, sampled every clocks_per_bit.
  - Stop bit sampled high: internal byte strobe for 1 cycle.
  - Stop bit sampled low: framing_error pulse, byte discarded, parser forced to H1.
- enable = 0: UART and parser held idle/H1, no pulses, outputs hold their values. Sampling resumes on the first falling edge after enable rises.
- Parser states and byte transitions:
  - H1: FF -> H2; anything else stays in H1.
  - H2: FF -> H3; else -> H1.
  - H3: FD -> RSV; FF stays in H3; else -> H1.
  - RSV: 00 -> ID; else -> H1.
  - ID: any byte -> LEN_L.
  - LEN_L -> LEN_H. If LEN < 4 -> H1.
  - INST: 0x55 -> ERR; else -> H1, no pulse.
  - ERR -> PARAM, or -> CRC_L if LEN = 4.
  - PARAM runs for LEN-4 raw bytes, then -> CRC_L -> CRC_H.
- LEN counts the raw (stuffed) bytes INST through CRC_H inclusive.
- Byte stuffing: in PARAM, an FD that immediately follows a raw FF FF FD sequence is dropped. It is not delivered and not counted in param_count. It still consumes LEN and is included in the CRC.
- CRC: CRC-16, poly 0x8005, init 0x0000, MSB-first, no reflection, no final XOR.
  - Covers every raw byte from the first FF through the last PARAM byte.
  - Header bytes are included. When H3 sees a repeated FF, the CRC restarts as if fed FF FF.
  - The received CRC is little-endian (CRC_L first).
  - The CRC update per byte must complete before the next byte strobe; a serial 8-cycle implementation is acceptable.
- Parameter capture: bytes 0..3 go to staging. Bytes beyond 4 are counted and CRC'd but not stored. param_count wraps at 16 bits.
- Completion, on the CRC_H strobe:
  - Match: packet_valid pulses and id/error/param_count/value update in the same cycle.
  - Mismatch: packet_crc_error pulses and outputs hold.
  - Either pulse occurs within 2 cycles of the stop-bit sample of CRC_H. Parser returns to H1.
- Back-to-back packets with zero idle bits between them must be received.

Test Plan:
- Ping status FF FF FD 00 01 07 00 55 00 06 04 26 65 5D at 4 Mbaud/12 MHz -> one packet_valid; id=0x01, error=0x00, param_count=3, value=0x00260406.
- Read status FF FF FD 00 01 08 00 55 00 A6 00 00 00 8C C0 -> packet_valid; param_count=4, value=0x000000A6.
- Same ping with last byte 5C -> packet_crc_error pulse only; outputs keep previous values.
- Stuffed parameters FF FF FD FD (plus leading noise byte 0x33 and a 1-cycle glitch low on the idle line) with correct CRC -> param_count=3, value=0x00FDFFFF; noise and glitch ignored.
- Stop bit forced low mid-packet -> framing_error pulse, no packet pulse. The next good packet is received.
- Reset asserted mid-PARAM, and separately enable=0 during a packet -> no pulses, outputs 0 / held respectively. The next packet after release is decoded correctly.
